// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter fed by the AXI-Lite UART register slave.
// Bytes pushed with wr_en/wr_data are queued in a FIFO_DEPTH-entry FIFO. Each byte is sent as
// an 8N1 frame on o_tx_serial, or as 8E1 when UART_TX_PARITY_EN is defined (optional build
// macro that adds an even-parity bit between the data bits and the stop bit).
//
// Ports:
//   S_AXI_ACLK     in   sole clock, rising edge
//   S_AXI_ARESETN  in   synchronous active-low reset
//   wr_en          in   push wr_data this cycle
//   wr_data        in   byte to transmit
//   wr_ready       out  FIFO not full (registered)
//   fifo_count     out  bytes waiting in FIFO, excluding the byte being shifted
//   overflow       out  sticky, set by a write while wr_ready=0
//   clr_overflow   in   clears overflow (a same-cycle set wins)
//   o_tx_serial    out  UART TX line, idle high
//   o_tx_active    out  high for the whole frame, start through stop
//   o_tx_done      out  one-cycle pulse on the last cycle of the stop bit
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FIFO_AW      = $clog2(FIFO_DEPTH)
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               wr_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    input  logic               clr_overflow,
    output logic               o_tx_serial,
    output logic               o_tx_active,
    output logic               o_tx_done
);

    localparam int unsigned        CntW   = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0]    CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   Full   = (FIFO_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd4;
`endif

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               wr_ready_q, wr_ready_d;
    logic               overflow_q, overflow_d;

    logic [2:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;

    logic               serial_q, serial_d;
    logic               active_q, active_d;
    logic               done_q, done_d;

    logic push, pop, bit_end;

    // wr_ready_q reflects the pre-edge count, so a same-cycle pop never admits a write when full.
    assign push    = wr_en && wr_ready_q;
    assign pop     = (state_q == StIdle) && (count_q != '0);
    assign bit_end = (cnt_q == CntMax);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (FIFO_AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (FIFO_AW + 1)'(1);
        end
        wr_ready_d = (count_d != Full);
        // Set has priority over clear.
        if (wr_en && !wr_ready_q) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Line outputs are registered from the current state, so the line trails the FSM by one
    // cycle: pop at edge N+1, start bit visible from edge N+2, single idle-high gap between frames.
    always_comb begin
        case (state_q)
            StStart:  serial_d = 1'b0;
            StData:   serial_d = shift_q[idx_q];
`ifdef UART_TX_PARITY_EN
            StParity: serial_d = ^shift_q;
`endif
            default:  serial_d = 1'b1;
        endcase
        active_d = (state_q != StIdle);
        done_d   = (state_q == StStop) && bit_end;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_ready_q <= wr_ready_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// A line monitor decodes every frame on o_tx_serial and compares it with the byte queued when
// the write was driven.
module tb_uart_tx_buffered;

    localparam int Cpb = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif
    localparam int FrameCycles = FrameBits * Cpb;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       clr_overflow;
    logic       o_tx_serial;
    logic       o_tx_active;
    logic       o_tx_done;

    uart_tx_buffered #(
        .CLKS_PER_BIT (Cpb),
        .FIFO_DEPTH   (16)
    ) u_dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow),
        .o_tx_serial   (o_tx_serial),
        .o_tx_active   (o_tx_active),
        .o_tx_done     (o_tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive/sample point: 2 time units after the active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] sb[$];

    // Line monitor state
    int          cyc = 0;
    int          mon_t = 0;
    bit          mon_busy = 0;
    logic [10:0] rx;
    int          done_cnt = 0;
    bit          gap_chk = 0;
    bit          have_prev = 0;
    int          prev_end = 0;
    int          burst_idx = 0;

    always @(negedge clk) begin
        logic [7:0]  b;
        logic [10:0] exp_frame;
        cyc++;
        if (o_tx_done) done_cnt++;
        if (!rst_n) begin
            mon_busy = 0;
            mon_t    = 0;
        end else if (!mon_busy) begin
            if (!o_tx_serial) begin
                mon_busy = 1;
                mon_t    = 1;
                rx       = '0;
                if (gap_chk && have_prev) check_eq("gap", cyc - prev_end, 2);
                if (gap_chk) begin
                    if (burst_idx >= 1) check_eq("cnt_at_pop", fifo_count, 16 - burst_idx);
                    burst_idx++;
                end
            end
        end else begin
            mon_t++;
            if (mon_t % Cpb == 2) rx[(mon_t - 2) / Cpb] = o_tx_serial;
            if (mon_t == FrameCycles - 1) check_eq("done_early", o_tx_done, 0);
            if (mon_t == FrameCycles) begin
                check_eq("done", o_tx_done, 1);
                check_eq("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    b = sb.pop_front();
`ifdef UART_TX_PARITY_EN
                    exp_frame = {1'b1, ^b, b, 1'b0};
`else
                    exp_frame = {1'b0, 1'b1, b, 1'b0};
`endif
                    check_eq("frame", rx, exp_frame);
                end
                prev_end  = cyc;
                have_prev = 1;
                mon_busy  = 0;
            end
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (sb.size() == 0 && !mon_busy) break;
        end
        check_eq("drain", sb.size() + int'(mon_busy), 0);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        bit low_seen;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        clr_overflow = 1'b0;
        repeat (3) step();
        check_eq("rst_serial", o_tx_serial, 1);
        check_eq("rst_active", o_tx_active, 0);
        check_eq("rst_done", o_tx_done, 0);
        check_eq("rst_wr_ready", wr_ready, 1);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        step();

        // Single byte: latency and framing
        done_cnt = 0;
        sb.push_back(8'h55);
        write_byte(8'h55);
        check_eq("single_cnt_after_wr", fifo_count, 1);
        check_eq("single_line_n", o_tx_serial, 1);
        step();
        check_eq("single_cnt_after_pop", fifo_count, 0);
        check_eq("single_line_n1", o_tx_serial, 1);
        check_eq("single_active_n1", o_tx_active, 0);
        step();
        check_eq("single_line_n2", o_tx_serial, 0);
        check_eq("single_active_n2", o_tx_active, 1);
        wait_idle(200);
        check_eq("single_cnt_end", fifo_count, 0);
        check_eq("single_done_pulses", done_cnt, 1);

        // Burst with overflow, clear race, push/pop at full
        done_cnt  = 0;
        gap_chk   = 1;
        have_prev = 0;
        burst_idx = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) sb.push_back(8'(i));
            write_byte(8'(i));
            if (i == 15) check_eq("burst_ready_15", wr_ready, 1);
            if (i == 16) check_eq("burst_ready_16", wr_ready, 0);
        end
        check_eq("burst_overflow", overflow, 1);
        check_eq("burst_count_full", fifo_count, 16);

        wr_en        = 1'b1;
        wr_data      = 8'hDD;
        clr_overflow = 1'b1;
        step();
        wr_en        = 1'b0;
        clr_overflow = 1'b0;
        check_eq("ovf_race", overflow, 1);
        check_eq("ovf_race_count", fifo_count, 16);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check_eq("ovf_clear", overflow, 0);

        for (int i = 0; i < 100; i++) begin
            if (o_tx_done) break;
            step();
        end
        check_eq("done_seen", o_tx_done, 1);
        // IDLE pops on the next edge while the FIFO is still full
        write_byte(8'hEE);
        check_eq("full_pop_overflow", overflow, 1);
        check_eq("full_pop_count", fifo_count, 15);
        check_eq("full_pop_ready", wr_ready, 1);

        wait_idle(1000);
        gap_chk = 0;
        check_eq("burst_count_end", fifo_count, 0);
        check_eq("burst_done_pulses", done_cnt, 17);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;

        // Reset mid-frame during data bit 3 of 0xA5 with three bytes queued
        sb.push_back(8'hA5);
        write_byte(8'hA5);
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        check_eq("pre_rst_count", fifo_count, 3);
        for (int i = 0; i < 100; i++) begin
            if (mon_busy && mon_t >= 18) break;
            step();
        end
        check_eq("in_bit3", mon_t >= 18 && mon_t <= 20, 1);
        rst_n = 1'b0;
        sb.delete();
        step();
        check_eq("midrst_serial", o_tx_serial, 1);
        check_eq("midrst_count", fifo_count, 0);
        check_eq("midrst_active", o_tx_active, 0);
        step();
        rst_n = 1'b1;
        low_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!o_tx_serial) low_seen = 1;
        end
        check_eq("no_tx_after_rst", low_seen, 0);

        // Traffic resumes after reset
        done_cnt = 0;
        sb.push_back(8'hC3);
        write_byte(8'hC3);
`ifdef UART_TX_PARITY_EN
        sb.push_back(8'h07);
        write_byte(8'h07);
`endif
        wait_idle(300);
        check_eq("resume_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Byte-stream UART transmitter that sits directly downstream of the AXI-Lite UART register slave.
- The slave pushes bytes written to its TX data register into an internal FIFO.
- This block drains the FIFO and serialises each byte as an 8N1 frame on the TX pin.
- It also reports FIFO occupancy, busy/done and a sticky overflow flag back to the slave for its status register.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- FIFO_AW, $clog2(FIFO_DEPTH), derived pointer width; never overridden.

Ports:
- S_AXI_ACLK  input  1  sole clock, rising edge.
- S_AXI_ARESETN  input  1  synchronous, active-low reset.
- wr_en  input  1  push wr_data this cycle.
- wr_data  input  8  byte to transmit.
- wr_ready  output  1  FIFO not full; registered.
- fifo_count  output  FIFO_AW+1  bytes waiting in FIFO (0..FIFO_DEPTH); excludes the byte being shifted.
- overflow  output  1  sticky; set when wr_en is asserted while wr_ready=0.
- clr_overflow  input  1  clears overflow.
- o_tx_serial  output  1  UART TX line, idle high.
- o_tx_active  output  1  high from START entry through the end of STOP.
- o_tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset values: o_tx_serial=1, o_tx_active=0, o_tx_done=0, wr_ready=1, fifo_count=0, overflow=0, FIFO pointers=0, state=IDLE.
- Reset is sampled only on the S_AXI_ACLK edge.
- Reset mid-frame abandons the frame and FIFO contents; o_tx_serial is 1 on the first edge with S_AXI_ARESETN=0.
- FIFO write: accepted iff wr_en && wr_ready. The byte is stored at the edge and fifo_count increments.
- A rejected write is dropped, the FIFO is unchanged and overflow is set.
- Overflow priority: a set in the same cycle as clr_overflow wins (overflow stays 1).
- Simultaneous push and pop leaves fifo_count unchanged.
- wr_ready is evaluated on pre-edge count, so a pop in the same cycle does not admit a write to a full FIFO.
- Pointers wrap modulo FIFO_DEPTH; fifo_count saturates naturally at FIFO_DEPTH and never underflows.
- FSM states: IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) drive the transitions.
- IDLE: o_tx_serial=1. If fifo_count!=0, pop the head into the shift register, go to START, clear the bit counter.
- START: o_tx_serial=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: o_tx_serial = shift[index], LSB first, each bit for CLKS_PER_BIT cycles; after index 7 go to STOP.
- STOP: o_tx_serial=1 for CLKS_PER_BIT cycles. o_tx_done=1 on the last cycle, then IDLE.
- Latency: a write at edge N into an empty FIFO with the FSM in IDLE gives pop at edge N+1 and o_tx_serial=0 from edge N+2.
- Frame length is 10*CLKS_PER_BIT cycles.
- Inter-frame gap is exactly 1 idle-high cycle when the FIFO stays non-empty.
- o_tx_active=0 during that IDLE cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state sits between DATA and STOP and drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11*CLKS_PER_BIT cycles (8E1).
- When undefined: no PARITY state and no parity logic; 8N1 as above.

Test Plan:
- All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=16.
- Single byte: write 0x55 from idle after reset → line low for 4 cycles starting 2 cycles after the write edge. Data bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high for 4 cycles. o_tx_done pulses once at cycle 40 of the frame; fifo_count returns to 0.
- Burst/overflow: 18 back-to-back writes 0x00..0x11 from idle → first 17 accepted, wr_ready=0 after the 17th, 18th dropped, overflow=1. 17 frames emitted in order 0x00..0x10, each separated by exactly 1 high cycle. fifo_count decrements per pop to 0.
- Overflow clear race: clr_overflow and a rejected write in the same cycle → overflow stays 1. clr_overflow alone on the next cycle → overflow=0.
- Reset mid-frame: assert S_AXI_ARESETN=0 during DATA bit 3 of 0xA5 with 3 bytes queued → next edge o_tx_serial=1, fifo_count=0, o_tx_active=0. After release no frame is sent until a new write.
- Parity (UART_TX_PARITY_EN defined): write 0x07 → after data bits 1,1,1,0,0,0,0,0 the parity bit is 1, then stop. Frame is 44 cycles; o_tx_done at cycle 44.
- Push/pop at full: FIFO at 16 while a frame ends and IDLE pops, write asserted that same cycle → write rejected, overflow=1, fifo_count=15 after the edge.
